// File: rtl/niosii_system_sysid_ext.sv
`default_nettype none
// ============================================================================
//  Module   : niosii_system_sysid_ext
//  Purpose  : System-identification and uptime peripheral for the Nios II
//             Avalon-MM interconnect. Returns a build ID and build timestamp,
//             and provides a free-running 2*DATA_W uptime counter with
//             coherent LO/HI snapshot reads, a scratch register and
//             control/status registers. Reads have one cycle of latency.
//
//  Ports    : clock          - sole clock, rising edge
//             reset_n        - synchronous active-low reset
//             address[2:0]   - word offset
//             read           - read request (one beat per cycle)
//             write          - write request (wins over a coincident read)
//             writedata      - write data, DATA_W bits
//             readdata       - registered read data, DATA_W bits
//             readdatavalid  - one-cycle pulse qualifying readdata
//
//  Register map (word offsets)
//             0 ID         RO   ID_VALUE
//             1 TIMESTAMP  RO   TIMESTAMP
//             2 UPTIME_LO  RO   counter low half; latches high half to shadow
//             3 UPTIME_HI  RO   shadow of counter high half
//             4 SCRATCH    RW
//             5 CTRL       RW   bit0 EN (reset 1), bit1 CLR (write-1 pulse)
//             6 STATUS     W1C  bit0 OVF (sticky)
//             7 reserved        reads 0, writes ignored
//
//  Revision : 1.0  initial release
// ============================================================================
module niosii_system_sysid_ext #(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  ID_VALUE    = '0,
    parameter logic [DATA_W-1:0]  TIMESTAMP   = DATA_W'(1427240862),
    parameter logic [DATA_W-1:0]  SCRATCH_RST = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid
);

    localparam int         c_CNT_W        = 2 * DATA_W;

    localparam logic [2:0] c_ADDR_ID      = 3'd0;
    localparam logic [2:0] c_ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] c_ADDR_UP_LO   = 3'd2;
    localparam logic [2:0] c_ADDR_UP_HI   = 3'd3;
    localparam logic [2:0] c_ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] c_ADDR_CTRL    = 3'd5;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_shadow;
    logic [DATA_W-1:0]  r_scratch;
    logic               r_en;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_readdata;
    logic               r_readdatavalid;

    // ------------------------------------------------------------------
    // Access decode. A cycle with both read and write high is treated
    // purely as a write: no read response and no shadow latch.
    // ------------------------------------------------------------------
    logic               w_rd;
    logic               w_wr_scratch;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic               w_clr;
    logic               w_ovf_w1c;
    logic               w_wrap;
    logic               w_latch_shadow;
    logic [DATA_W-1:0]  w_rd_mux;

    assign w_rd           = read & ~write;
    assign w_wr_scratch   = write & (address == c_ADDR_SCRATCH);
    assign w_wr_ctrl      = write & (address == c_ADDR_CTRL);
    assign w_wr_status    = write & (address == c_ADDR_STATUS);
    assign w_clr          = w_wr_ctrl & writedata[1];
    assign w_ovf_w1c      = w_wr_status & writedata[0];
    assign w_latch_shadow = w_rd & (address == c_ADDR_UP_LO);

    // An increment from all-ones is the only way to wrap; a CLR in the same
    // cycle takes priority over counting, so it suppresses the wrap.
    assign w_wrap = r_en & ~w_clr & (&r_count);

    // ------------------------------------------------------------------
    // Read data selection, using the register values held before this
    // edge so UPTIME_LO returns the pre-increment count.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_ID:      w_rd_mux = ID_VALUE;
            c_ADDR_TSTAMP:  w_rd_mux = TIMESTAMP;
            c_ADDR_UP_LO:   w_rd_mux = r_count[DATA_W-1:0];
            c_ADDR_UP_HI:   w_rd_mux = r_shadow;
            c_ADDR_SCRATCH: w_rd_mux = r_scratch;
            c_ADDR_CTRL:    w_rd_mux = {{(DATA_W-1){1'b0}}, r_en};
            c_ADDR_STATUS:  w_rd_mux = {{(DATA_W-1){1'b0}}, r_ovf};
            default:        w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Uptime counter: reset > CLR > enable > hold. EN is taken from the
    // register value held before the edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_clr) begin
            r_count <= '0;
        end else if (r_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Sticky overflow flag; a coincident set beats the W1C.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_w1c) begin
            r_ovf <= 1'b0;
        end
    end

    // The high half is captured on the same edge that returns the low half,
    // so the LO/HI pair is coherent however late the HI read comes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (w_latch_shadow) begin
            r_shadow <= r_count[c_CNT_W-1:DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Writable registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_scratch <= SCRATCH_RST;
        end else if (w_wr_scratch) begin
            r_scratch <= writedata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_en <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_en <= writedata[0];
        end
    end

    // ------------------------------------------------------------------
    // Registered read response. readdata holds between responses.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

endmodule
`default_nettype wire

// File: tb/tb_niosii_system_sysid_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_niosii_system_sysid_ext
//  Purpose  : Directed self-checking bench for niosii_system_sysid_ext.
//             A 32-bit instance covers ID/timestamp, scratch, CLR, enable
//             and snapshot reads; an 8-bit instance covers LO->HI carry,
//             the full 16-bit wrap and overflow set/clear behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_niosii_system_sysid_ext;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 32-bit instance bus
    logic [2:0]  a_addr = '0;
    logic        a_rd = 1'b0;
    logic        a_wr = 1'b0;
    logic [31:0] a_wd = '0;
    logic [31:0] a_rdata;
    logic        a_rdv;

    // 8-bit instance bus
    logic [2:0]  b_addr = '0;
    logic        b_rd = 1'b0;
    logic        b_wr = 1'b0;
    logic [7:0]  b_wd = '0;
    logic [7:0]  b_rdata;
    logic        b_rdv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    niosii_system_sysid_ext #(
        .DATA_W      (32),
        .ID_VALUE    (32'hCAFE0001),
        .TIMESTAMP   (32'd1427240862),
        .SCRATCH_RST (32'h0BADF00D)
    ) u_dut32 (
        .clock         (clk),
        .reset_n       (rst_n),
        .address       (a_addr),
        .read          (a_rd),
        .write         (a_wr),
        .writedata     (a_wd),
        .readdata      (a_rdata),
        .readdatavalid (a_rdv)
    );

    niosii_system_sysid_ext #(
        .DATA_W      (8),
        .ID_VALUE    (8'h42),
        .TIMESTAMP   (8'h5A),
        .SCRATCH_RST (8'h00)
    ) u_dut8 (
        .clock         (clk),
        .reset_n       (rst_n),
        .address       (b_addr),
        .read          (b_rd),
        .write         (b_wr),
        .writedata     (b_wd),
        .readdata      (b_rdata),
        .readdatavalid (b_rdv)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_a(input logic [2:0] ad, input logic [31:0] d);
        a_addr = ad;
        a_wd   = d;
        a_wr   = 1'b1;
        @(posedge clk);
        #1;
        a_wr   = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [2:0] ad, output logic [31:0] d);
        a_addr = ad;
        a_rd   = 1'b1;
        @(posedge clk);
        #1;
        a_rd   = 1'b0;
        check({tag, "_rdv"}, a_rdv, 1'b1);
        d = a_rdata;
    endtask

    task automatic wr_b(input logic [2:0] ad, input logic [7:0] d);
        b_addr = ad;
        b_wd   = d;
        b_wr   = 1'b1;
        @(posedge clk);
        #1;
        b_wr   = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [2:0] ad, output logic [7:0] d);
        b_addr = ad;
        b_rd   = 1'b1;
        @(posedge clk);
        #1;
        b_rd   = 1'b0;
        check({tag, "_rdv"}, b_rdv, 1'b1);
        d = b_rdata;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v2;
        logic [7:0]  b;

        // ---------------- reset, read issued during reset ----------------
        a_rd   = 1'b1;
        a_addr = 3'd0;
        idle(3);
        check("reset_rdv", a_rdv, 1'b0);
        check("reset_rdata", a_rdata, 32'h0);
        a_rd  = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // ---------------- fixed words ----------------
        rd_a("id", 3'd0, v);        check("id", v, 32'hCAFE0001);
        rd_a("tstamp", 3'd1, v);    check("tstamp", v, 32'd1427240862);
        idle(1);
        check("idle_rdv", a_rdv, 1'b0);
        check("idle_hold", a_rdata, 32'd1427240862);
        rd_a("rsvd", 3'd7, v);      check("rsvd", v, 32'h0);
        rd_a("ctrl_rst", 3'd5, v);  check("ctrl_rst", v, 32'h1);
        rd_a("stat_rst", 3'd6, v);  check("stat_rst", v, 32'h0);

        // ---------------- scratch ----------------
        rd_a("scr_rst", 3'd4, v);   check("scr_rst", v, 32'h0BADF00D);
        wr_a(3'd4, 32'hA5A5A5A5);
        rd_a("scr_wr", 3'd4, v);    check("scr_wr", v, 32'hA5A5A5A5);
        wr_a(3'd0, 32'hFFFFFFFF);
        rd_a("ro_wr", 3'd0, v);     check("ro_wr", v, 32'hCAFE0001);
        wr_a(3'd7, 32'hFFFFFFFF);
        rd_a("rsvd_wr", 3'd7, v);   check("rsvd_wr", v, 32'h0);

        // reset asserted mid-operation with a read in the same cycle
        rst_n  = 1'b0;
        a_addr = 3'd4;
        a_rd   = 1'b1;
        idle(1);
        check("midrst_rdv", a_rdv, 1'b0);
        check("midrst_rdata", a_rdata, 32'h0);
        a_rd  = 1'b0;
        rst_n = 1'b1;
        rd_a("scr_rst2", 3'd4, v);  check("scr_rst2", v, 32'h0BADF00D);

        // ---------------- CLR then LO/HI back-to-back ----------------
        wr_a(3'd5, 32'h3);          // CLR, stay enabled
        idle(100);
        rd_a("lo_100", 3'd2, v);    check("lo_100", v, 32'd100);
        rd_a("hi_100", 3'd3, v);    check("hi_100", v, 32'd0);
        rd_a("lo_102", 3'd2, v);    check("lo_102", v, 32'd102);
        rd_a("lo_103", 3'd2, v);    check("lo_103", v, 32'd103);

        // CLR then LO, 50 idle cycles, HI
        wr_a(3'd5, 32'h3);
        idle(100);
        rd_a("lo_gap", 3'd2, v);    check("lo_gap", v, 32'd100);
        idle(50);
        rd_a("hi_gap", 3'd3, v);    check("hi_gap", v, 32'd0);

        // ---------------- CLR with disable, then re-enable ----------------
        wr_a(3'd5, 32'h2);
        idle(20);
        rd_a("dis_lo", 3'd2, v);    check("dis_lo", v, 32'd0);
        rd_a("dis_ctrl", 3'd5, v);  check("dis_ctrl", v, 32'h0);
        idle(5);
        rd_a("dis_lo2", 3'd2, v);   check("dis_lo2", v, 32'd0);
        wr_a(3'd5, 32'h1);
        idle(10);
        rd_a("resume_lo", 3'd2, v);
        // EN may govern the write edge itself or start on the next one
        check("resume_range", (v == 32'd10) || (v == 32'd11), 1'b1);
        idle(10);
        rd_a("resume_lo2", 3'd2, v2);
        check("resume_rate", v2 - v, 32'd11);

        // ---------------- simultaneous read+write ----------------
        a_addr = 3'd4;
        a_wd   = 32'h12345678;
        a_rd   = 1'b1;
        a_wr   = 1'b1;
        idle(1);
        a_rd   = 1'b0;
        a_wr   = 1'b0;
        check("rw_rdv", a_rdv, 1'b0);
        rd_a("rw_scr", 3'd4, v);    check("rw_scr", v, 32'h12345678);

        // ---------------- 8-bit instance: carry and wrap ----------------
        rd_b("b_id", 3'd0, b);      check("b_id", b, 8'h42);
        rd_b("b_ts", 3'd1, b);      check("b_ts", b, 8'h5A);
        wr_b(3'd5, 8'h03);          // counter 0 after this edge (E)
        idle(254);
        rd_b("b_lo_fe", 3'd2, b);   check("b_lo_fe", b, 8'hFE);   // E+255
        rd_b("b_hi0", 3'd3, b);     check("b_hi0", b, 8'h00);     // E+256
        rd_b("b_lo_00", 3'd2, b);   check("b_lo_00", b, 8'h00);   // E+257 -> 0x0100
        rd_b("b_hi1", 3'd3, b);     check("b_hi1", b, 8'h01);     // E+258
        rd_b("b_ovf0", 3'd6, b);    check("b_ovf0", b, 8'h00);    // E+259
        idle(65274);
        rd_b("b_lo_fd", 3'd2, b);   check("b_lo_fd", b, 8'hFD);   // E+65534 -> 0xFFFD
        rd_b("b_hi_ff", 3'd3, b);   check("b_hi_ff", b, 8'hFF);   // E+65535
        wr_b(3'd6, 8'h01);          // W1C on the wrap edge E+65536
        rd_b("b_ovf_win", 3'd6, b); check("b_ovf_win", b, 8'h01);
        rd_b("b_lo_wrap", 3'd2, b); check("b_lo_wrap", b, 8'h01); // 0x0001
        rd_b("b_hi_wrap", 3'd3, b); check("b_hi_wrap", b, 8'h00);
        rd_b("b_ovf_st", 3'd6, b);  check("b_ovf_st", b, 8'h01);
        wr_b(3'd6, 8'h01);
        rd_b("b_ovf_clr", 3'd6, b); check("b_ovf_clr", b, 8'h00);
        wr_b(3'd5, 8'h02);          // CLR does not touch OVF, shadow
        rd_b("b_hi_keep", 3'd3, b); check("b_hi_keep", b, 8'h00);
        rd_b("b_ctrl", 3'd5, b);    check("b_ctrl", b, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/niosii_system_sysid_ext.md
# niosII_system_sysid_ext

Parametrised system-identification and uptime peripheral on the Nios II Avalon-MM interconnect. It returns a build ID and build timestamp at fixed offsets, like the basic sysid slave. It adds a free-running 2×DATA_W uptime counter with coherent snapshot reads, a scratch register, and control/status registers. Reads are registered, with one-cycle latency and `readdatavalid`.

## Interface
Parameters:
- `DATA_W`, 32: register/bus width; must be ≥ 8.
- `ID_VALUE`, 0: system ID word returned at offset 0.
- `TIMESTAMP`, 1427240862: build timestamp returned at offset 1.
- `SCRATCH_RST`, 0: reset value of the scratch register.

Ports:
- `clock`  in  1: sole clock; all logic on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset, sampled on `clock`.
- `address`  in  3: word offset.
- `read`  in  1: read request, single cycle per beat.
- `write`  in  1: write request.
- `writedata`  in  DATA_W: write data.
- `readdata`  out  DATA_W: registered read data.
- `readdatavalid`  out  1: one-cycle pulse qualifying `readdata`.

## Operation
Register map (word offsets):
- 0 ID (RO): `ID_VALUE`.
- 1 TIMESTAMP (RO): `TIMESTAMP`.
- 2 UPTIME_LO (RO): counter[DATA_W-1:0]. The same read latches counter[2·DATA_W-1:DATA_W] into the shadow register.
- 3 UPTIME_HI (RO): shadow register value. Reading it does not reload the shadow.
- 4 SCRATCH (RW): plain storage.
- 5 CTRL (RW):
  - bit0 EN, reset 1: counter enable.
  - bit1 CLR, write-1 pulse: reads as 0.
  - Other bits read 0.
- 6 STATUS: bit0 OVF is sticky and write-1-to-clear. Other bits read 0.
- 7: reads 0; writes ignored.
- Writes to RO offsets are ignored.

Uptime counter:
- Width 2·DATA_W, unsigned.
- Each cycle, priority order:
  1. Reset: counter ← 0.
  2. CLR written this cycle: counter ← 0.
  3. EN=1: counter ← counter+1.
  4. Otherwise hold.
- Wrap from all-ones to 0 sets OVF.
- If an OVF set and a W1C of OVF occur in the same cycle, the set wins (OVF=1).
- CLR does not touch OVF, the shadow register or EN. A CTRL write with bit0=0 and bit1=1 clears the counter and disables it.

Bus rules:
- No `waitrequest`; every access completes.
- If `read` and `write` are both high, the cycle is a write only: no `readdatavalid`, and no shadow latch.
- The read value is sampled at the request edge. For UPTIME_LO this is the pre-increment count.
- Reading SCRATCH/CTRL in the cycle after a write returns the new value.

Reset values:
- `readdata`=0, `readdatavalid`=0.
- Counter=0, shadow=0, OVF=0, EN=1, SCRATCH=`SCRATCH_RST`.

## Timing
- Read at edge N → `readdata`/`readdatavalid` valid after edge N+1. `readdatavalid` is high exactly one cycle per read.
- `readdata` holds its last value while `readdatavalid`=0.
- Back-to-back reads every cycle are supported, at full throughput with one result per cycle.
- Write takes effect at the request edge. CLR zeroes the counter at that edge, so the counter reads 0 at the next sample.
- Counter with EN=1 advances exactly 1 per clock.
- Shadow latch coincides with the UPTIME_LO read edge, so LO+HI is a coherent 2·DATA_W value regardless of the delay before the HI read.
- Reset asserted mid-operation: all state returns to reset values on that edge. A read issued in the reset cycle produces no `readdatavalid`.

## Test plan
- Reset, then read offsets 0, 1, 7 with `ID_VALUE`=32'hCAFE0001 → `readdata` 32'hCAFE0001, 1427240862, 0, each one cycle after its request, with `readdatavalid` pulses.
- Write 32'hA5A5A5A5 to SCRATCH, then read it the next cycle → 32'hA5A5A5A5. Assert reset, then read → `SCRATCH_RST`.
- Counter pre-set via CLR, then run ~100 cycles. Read LO and HI back-to-back, and separately with 50 idle cycles between them → LO equals the cycle count since CLR, and HI is unchanged (0) in both cases.
- Wrap/carry check with `DATA_W`=8: run until LO wraps from 8'hFF to 8'h00 → the later snapshot shows HI incremented by 1. Run to 16'hFFFF→0 → OVF=1.
- Clear OVF:
  - W1C STATUS → OVF=0.
  - W1C in the same cycle as a wrap → OVF remains 1.
- Write CTRL=2'b10 → counter 0 and stays 0 for 20 cycles. Write CTRL=1 → counter resumes at 1 per cycle.
- Simultaneous `read`=`write`=1 to SCRATCH with 32'h12345678 → no `readdatavalid`. A subsequent read returns 32'h12345678.
